// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The FSM state encoding, default timing values and a width helper live here.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam int unsigned DEF_TIMEOUT = 25000;
    localparam int unsigned DEF_GAP_CYC = 0;

    // Bits needed to hold 0..v-1; never less than 1 so a counter always exists.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping around. The pointer register itself belongs to the caller.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_o && ((req_i >> i) & NUM_REQ'(1)) != '0 && i >= 32'(ptr_i)) begin
                any_o = 1'b1;
                gnt_o = NUM_REQ'(1) << i;
                idx_o = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_o && ((req_i >> i) & NUM_REQ'(1)) != '0) begin
                any_o = 1'b1;
                gnt_o = NUM_REQ'(1) << i;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART byte transmitter between NUM_REQ message sources, round-robin,
// sending each granted message MSB-first with a per-byte tx_done watchdog.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MSG_BYTES = 4,
    parameter int unsigned LEN_W     = 3,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*MSG_BYTES*8-1:0] req_data,
    input  logic [NUM_REQ*LEN_W-1:0]       req_len,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           req_err,
    output logic                           busy,
    output logic                           tx_en,
    output logic [7:0]                     tx_data,
    input  logic                           tx_done
);

    localparam int unsigned IDX_W    = clog2(NUM_REQ);
    localparam int unsigned MSG_W    = MSG_BYTES * 8;
    localparam int unsigned TMO_W    = clog2(TIMEOUT);
    localparam int unsigned GAP_W    = clog2(GAP_CYC + 1);
    localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [MSG_W-1:0]     shadow_q, shadow_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     bidx_q, bidx_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 zero_q, zero_d;
    logic                 tmo_abort;

    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 tx_en_q, tx_en_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0]   g_onehot;
    logic [IDX_W-1:0]     g_idx;
    logic                 g_any;
    logic [MSG_W-1:0]     cap_data;
    logic [LEN_W-1:0]     raw_len;
    logic [LEN_W-1:0]     eff_len;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (g_onehot),
        .idx_o (g_idx),
        .any_o (g_any)
    );

    function automatic logic [7:0] byte_at(input logic [MSG_W-1:0] d, input logic [LEN_W-1:0] k);
        logic [MSG_W-1:0] sh;
        sh = d << (32'(k) * 8);
        return sh[MSG_W-1 -: 8];
    endfunction

    always_comb begin
        cap_data = MSG_W'(req_data >> (32'(g_idx) * MSG_W));
        raw_len  = LEN_W'(req_len >> (32'(g_idx) * LEN_W));
        eff_len  = (32'(raw_len) > MSG_BYTES) ? LEN_W'(MSG_BYTES) : raw_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            shadow_q  <= '0;
            len_q     <= '0;
            bidx_q    <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            zero_q    <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
            len_q     <= len_d;
            bidx_q    <= bidx_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            zero_q    <= zero_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        shadow_d  = shadow_q;
        len_d     = len_q;
        bidx_d    = bidx_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        zero_d    = zero_q;
        tmo_abort = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (g_any) begin
                    sel_d    = g_idx;
                    shadow_d = cap_data;
                    len_d    = eff_len;
                    bidx_d   = '0;
                    if (eff_len == '0) begin
                        state_d = S_DONE;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tx_done) begin
                    if (32'(bidx_q) + 1 < 32'(len_q)) begin
                        bidx_d = bidx_q + LEN_W'(1);
                        gap_d  = '0;
                        state_d = (GAP_CYC == 0) ? S_SEND : S_GAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    tmo_abort = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                // A zero-length grant spends an extra DONE cycle so req_done trails req_ack.
                if (zero_q) begin
                    zero_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    ptr_d   = (32'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d     = '0;
        done_d    = '0;
        err_d     = tmo_abort;
        busy_d    = (state_d != S_IDLE);
        tx_en_d   = (state_d == S_SEND);
        tx_data_d = tx_data_q;
        if (state_q == S_IDLE && g_any) begin
            ack_d = g_onehot;
        end
        if ((state_q == S_WAIT && state_d == S_DONE) || (state_q == S_DONE && zero_q)) begin
            done_d = NUM_REQ'(1) << sel_q;
        end
        if (state_d == S_SEND) begin
            tx_data_d = byte_at(shadow_d, bidx_d);
        end
    end

    assign req_ack  = ack_q;
    assign req_done = done_q;
    assign req_err  = err_q;
    assign busy     = busy_q;
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;

endmodule
